game_sequencer: RTL



---
 rtl/game_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// Game sequencer: physics tick, jump gating, collision, lives and score.
// Optional HISCORE_EN adds a best-score register and output port.
module game_sequencer #(
  parameter int TICK_DIV   = 25000,
  parameter int SCORE_DIV  = 100,
  parameter int HIT_TICKS  = 1000,
  parameter int LIVES_INIT = 3,
  parameter int PLAYER_W   = 20,
  parameter int PLAYER_H   = 20,
  parameter int OBS_W      = 20,
  parameter int OBS_H      = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        button,
  input  logic [15:0] x_player,
  input  logic [15:0] y_player,
  input  logic [15:0] x_obs,
  input  logic [15:0] y_obs,
  output logic        tick,
  output logic        jump_req,
  output logic [1:0]  state,
  output logic [1:0]  lives,
  output logic [15:0] score,
  output logic        collide
`ifdef HISCORE_EN
  ,
  output logic [15:0] hiscore
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HIT  = 2'd2,
    S_OVER = 2'd3
  } state_e;

  localparam int DW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)      : 1;
  localparam int SW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV)     : 1;
  localparam int HW = (HIT_TICKS > 1) ? $clog2(HIT_TICKS + 1) : 1;

  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SC_MAX  = SW'(SCORE_DIV - 1);
  localparam logic [HW-1:0] HIT_LD  = HW'(HIT_TICKS);
  localparam logic [1:0]    LV_INIT = 2'(LIVES_INIT);

  state_e        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [SW-1:0] sc_q, sc_d;
  logic [HW-1:0] hit_q, hit_d;
  logic [1:0]    lives_q, lives_d;
  logic [15:0]   score_q, score_d;
  logic          tick_q, tick_d;
  logic          jump_q, jump_d;
  logic          coll_q, coll_d;
  logic          btn_q;

  logic press;
  logic running;
  logic div_wrap;

  assign press    = button & ~btn_q;
  assign running  = (state_q == S_RUN) || (state_q == S_HIT);
  assign div_wrap = (div_q == DIV_MAX);

  // Box overlap at 17 bits so the far edges never wrap.
  logic [16:0] xp, yp, xo, yo;
  logic [16:0] xp_r, yp_b, xo_r, yo_b;
  assign xp   = {1'b0, x_player};
  assign yp   = {1'b0, y_player};
  assign xo   = {1'b0, x_obs};
  assign yo   = {1'b0, y_obs};
  assign xp_r = xp + 17'(PLAYER_W);
  assign yp_b = yp + 17'(PLAYER_H);
  assign xo_r = xo + 17'(OBS_W);
  assign yo_b = yo + 17'(OBS_H);
  assign coll_d = (xp < xo_r) && (xo < xp_r)
               && (yp < yo_b) && (yo < yp_b);

`ifdef HISCORE_EN
  logic [15:0] hi_q, hi_d;
`endif

  // Next-state: game FSM, divider, score, lives and hit timer.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    score_d = score_q;
    sc_d    = sc_q;
    hit_d   = hit_q;
    jump_d  = 1'b0;
    div_d   = '0;
    if (running) begin
      div_d = div_wrap ? '0 : div_q + DW'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        if (press) begin
          state_d = S_RUN;
          score_d = '0;
          sc_d    = '0;
          lives_d = LV_INIT;
        end
      end
      S_RUN, S_HIT: begin
        jump_d = press;
        if (tick_q) begin
          if (sc_q == SC_MAX) begin
            sc_d = '0;
            if (score_q != 16'hFFFF) begin
              score_d = score_q + 16'd1;
            end
          end else begin
            sc_d = sc_q + SW'(1);
          end
          if (state_q == S_RUN) begin
            if (coll_q) begin
              if (lives_q == 2'd1) begin
                lives_d = 2'd0;
                state_d = S_OVER;
              end else begin
                lives_d = lives_q - 2'd1;
                state_d = S_HIT;
                hit_d   = HIT_LD;
              end
            end
          end else begin
            if (hit_q <= HW'(1)) begin
              hit_d   = '0;
              state_d = S_RUN;
            end else begin
              hit_d = hit_q - HW'(1);
            end
          end
        end
      end
      S_OVER: begin
        if (press) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    tick_d = running && div_wrap
          && ((state_d == S_RUN) || (state_d == S_HIT));
  end

`ifdef HISCORE_EN
  // Best score latched when a game ends.
  always_comb begin
    hi_d = hi_q;
    if ((state_d == S_OVER) && (state_q != S_OVER)
        && (score_d > hi_q)) begin
      hi_d = score_d;
    end
  end
`endif

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      sc_q    <= '0;
      hit_q   <= '0;
      lives_q <= LV_INIT;
      score_q <= '0;
      tick_q  <= 1'b0;
      jump_q  <= 1'b0;
      coll_q  <= 1'b0;
      btn_q   <= 1'b0;
`ifdef HISCORE_EN
      hi_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      sc_q    <= sc_d;
      hit_q   <= hit_d;
      lives_q <= lives_d;
      score_q <= score_d;
      tick_q  <= tick_d;
      jump_q  <= jump_d;
      coll_q  <= coll_d;
      btn_q   <= button;
`ifdef HISCORE_EN
      hi_q    <= hi_d;
`endif
    end
  end

  assign tick     = tick_q;
  assign jump_req = jump_q;
  assign state    = state_q;
  assign lives    = lives_q;
  assign score    = score_q;
  assign collide  = coll_q;
`ifdef HISCORE_EN
  assign hiscore  = hi_q;
`endif

endmodule
